if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage that sits directly downstream of the program counter register and feeds the decode stage.
- Takes the current PC and PC+4, issues in-order requests to instruction memory over a req/gnt plus rvalid protocol, and buffers responses in a DEPTH-entry queue.
- Presents instructions to decode with a valid/ready handshake.
- Asserts o_pc_stall so the PC holds when a fetch is not accepted, and supports flush on branch/jump redirect, including discard of in-flight responses.

Parameters:
NBITS, 32, address/instruction width
DEPTH, 4, queue entries, which also bounds outstanding requests; power of two, >=2
PTRW, clog2(DEPTH), derived pointer width; not overridden

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_reset  in  1  asynchronous, active-low reset
i_PC  in  NBITS  fetch address from the PC stage
i_PC_4  in  NBITS  PC+4 from the PC stage, carried with the instruction
o_pc_stall  out  1  high = this cycle's PC was not accepted; PC stage must hold
o_imem_req  out  1  fetch request
o_imem_addr  out  NBITS  fetch address, equals i_PC
i_imem_gnt  in  1  memory accepts request this cycle
i_imem_rvalid  in  1  response valid; responses arrive in request order
i_imem_rdata  in  NBITS  instruction word
o_valid  out  1  instruction available to decode
i_ready  in  1  decode accepts instruction
o_instr  out  NBITS  head instruction
o_instr_pc_4  out  NBITS  PC+4 of the head instruction
i_flush  in  1  redirect: discard queued and in-flight fetches

Behaviour:
- Storage:
  - Queue entries hold {pc4, instr, filled}.
  - Three pointers: wptr (allocate), fptr (fill), rptr (pop).
  - alloc_cnt = wptr - rptr, range 0..DEPTH; pointers are one bit wider than PTRW and wrap modulo 2*DEPTH.
- Request:
  - o_imem_req = i_reset & (state==RUN) & !i_flush & (alloc_cnt < DEPTH).
  - o_imem_addr = i_PC, combinational.
  - Accept = o_imem_req & i_imem_gnt. On accept: entry[wptr] <= {i_PC_4, x, filled=0}; wptr++.
  - o_pc_stall = !accept.
- Fill:
  - In RUN, i_imem_rvalid writes i_imem_rdata to entry[fptr], sets filled=1, and increments fptr.
  - rvalid with fptr==wptr is a protocol error: ignored, and flagged by a bench assertion.
- Output:
  - o_valid = (state==RUN) & entry[rptr].filled & (alloc_cnt!=0).
  - o_instr and o_instr_pc_4 come from entry[rptr].
  - Pop = o_valid & i_ready & !i_flush; pop clears filled and increments rptr.
  - No bypass: rvalid in cycle N gives o_valid at the earliest in N+1. Memory returns rvalid at the earliest 1 cycle after gnt.
- Full:
  - The request decision uses the registered alloc_cnt, so a pop in the same cycle does not free a slot until the next cycle.
  - Allocate, fill and pop may all occur in one cycle.
- FSM, 2 states:
  - RUN: normal operation.
  - On i_flush:
    - drop_cnt <= (wptr - fptr) - (i_imem_rvalid ? 1 : 0).
    - wptr, fptr and rptr all <= 0; every filled bit is cleared.
    - Next state = DRAIN if the new drop_cnt != 0, else RUN.
  - DRAIN: req=0 and o_valid=0. Each i_imem_rvalid decrements drop_cnt and its data is discarded. At drop_cnt==1 with rvalid, go to RUN.
  - i_flush while in DRAIN: no effect, since nothing is allocated.
- Flush cycle:
  - No accept, no pop; o_pc_stall=1.
  - The PC stage loads the redirect target and the next cycle fetches it.
- Reset, active low, asynchronous:
  - state=RUN; all pointers=0; drop_cnt=0; all filled=0.
  - Outputs while in reset: o_valid=0, o_imem_req=0, o_pc_stall=1, o_instr/o_instr_pc_4 = 0 (entries cleared).
  - Mid-operation reset discards everything immediately, without a clock edge; memory shares this reset.

Test Plan:
- Single fetch: after reset release, i_PC=0x0, i_PC_4=0x4, gnt=1; rvalid next cycle with rdata=0x20080005; ready=1 -> o_valid=1 the cycle after rvalid with o_instr=0x20080005 and o_instr_pc_4=0x4; pop leaves alloc_cnt=0.
- Backpressure: ready=0, gnt=1, 1-cycle memory latency, PCs 0x0/0x4/0x8/0xC -> after 4 accepts o_imem_req=0 and o_pc_stall=1. Raise ready -> 4 instructions pop in order, and o_imem_req reasserts the cycle after the first pop.
- Grant stall: gnt=0 for 3 cycles at i_PC=0x20 -> o_pc_stall=1 each cycle, alloc_cnt unchanged. gnt=1 -> one accept with pc4=0x24.
- Flush drain: accepts at 0x10 and 0x14, i_flush before any rvalid -> DRAIN with drop_cnt=2, o_valid=0, req=0. The two rvalids are discarded, then RUN. Fetch at 0x40 is delivered with pc4=0x44, and no stale data appears.
- Flush with coincident rvalid: 2 outstanding, i_flush and rvalid in the same cycle -> drop_cnt=1; one more rvalid is dropped, then RUN.
- Async reset: 3 entries queued, o_valid=1; assert i_reset=0 between clock edges -> o_valid=0 and o_imem_req=0 immediately. After release, alloc_cnt=0 and the first fetch behaves as in the single-fetch case.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues in-order req/gnt fetches at i_PC, queues responses,
// and hands instructions to decode via valid/ready. A flush drains in-flight responses.
module if_fetch_unit #(
  parameter int NBITS = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NBITS-1:0]         i_PC,
  input  logic [NBITS-1:0]         i_PC_4,
  output logic                     o_pc_stall,
  output logic                     o_imem_req,
  output logic [NBITS-1:0]         o_imem_addr,
  input  logic                     i_imem_gnt,
  input  logic                     i_imem_rvalid,
  input  logic [NBITS-1:0]         i_imem_rdata,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [NBITS-1:0]         o_instr,
  output logic [NBITS-1:0]         o_instr_pc_4,
  input  logic                     i_flush,
  output logic                     o_dbg_state,
  output logic [$clog2(DEPTH):0]   o_dbg_alloc_cnt,
  output logic [$clog2(DEPTH):0]   o_dbg_drop_cnt
);
  // Handshakes: a fetch is accepted when o_imem_req & i_imem_gnt; an instruction is
  // consumed when o_valid & i_ready (never during a flush cycle).
  localparam int PTRW = $clog2(DEPTH);
  localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [PTRW:0]     wptr_q, wptr_d, fptr_q, fptr_d, rptr_q, rptr_d;
  logic [PTRW:0]     drop_q, drop_d;
  logic [PTRW:0]     alloc_cnt, inflight;
  logic [NBITS-1:0]  pc4_q   [DEPTH];
  logic [NBITS-1:0]  instr_q [DEPTH];
  logic [DEPTH-1:0]  filled_q;
  logic [PTRW-1:0]   widx, fidx, ridx;
  logic              in_run, flush_run, fill_ok, fill, accept, pop;

  assign alloc_cnt = wptr_q - rptr_q;
  assign inflight  = wptr_q - fptr_q;
  assign widx      = wptr_q[PTRW-1:0];
  assign fidx      = fptr_q[PTRW-1:0];
  assign ridx      = rptr_q[PTRW-1:0];
  // A response with nothing outstanding is a protocol error and is ignored.
  assign fill_ok   = i_imem_rvalid & (inflight != '0);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      ST_RUN: begin
        if (i_flush) begin
          drop_d  = inflight - {{PTRW{1'b0}}, fill_ok};
          state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (i_imem_rvalid) begin
          drop_d = drop_q - 1'b1;
          if (drop_q == {{PTRW{1'b0}}, 1'b1}) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin : fsm_out
    in_run     = (state_q == ST_RUN);
    flush_run  = in_run & i_flush;
    o_imem_req = i_reset & in_run & ~i_flush & (alloc_cnt < FULL_CNT);
    o_valid    = in_run & filled_q[ridx] & (alloc_cnt != '0);
  end

  assign accept       = o_imem_req & i_imem_gnt;
  assign pop          = o_valid & i_ready & ~i_flush;
  assign fill         = in_run & ~i_flush & fill_ok;
  assign o_pc_stall   = ~accept;
  assign o_imem_addr  = i_PC;
  assign o_instr      = instr_q[ridx];
  assign o_instr_pc_4 = pc4_q[ridx];

  assign o_dbg_state     = state_q;
  assign o_dbg_alloc_cnt = alloc_cnt;
  assign o_dbg_drop_cnt  = drop_q;

  always_comb begin : ptr_next
    wptr_d = wptr_q + {{PTRW{1'b0}}, accept};
    fptr_d = fptr_q + {{PTRW{1'b0}}, fill};
    rptr_d = rptr_q + {{PTRW{1'b0}}, pop};
    if (flush_run) begin
      wptr_d = '0;
      fptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wptr_q <= '0;
      fptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      fptr_q <= fptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Allocate, fill and pop always target distinct slots, so their order here is irrelevant.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc4_q[i]   <= '0;
        instr_q[i] <= '0;
      end
    end else if (flush_run) begin
      filled_q <= '0;
    end else begin
      if (accept) begin
        pc4_q[widx]    <= i_PC_4;
        filled_q[widx] <= 1'b0;
      end
      if (fill) begin
        instr_q[fidx]  <= i_imem_rdata;
        filled_q[fidx] <= 1'b1;
      end
      if (pop) filled_q[ridx] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: single fetch, backpressure, grant stall,
// flush drain, flush with coincident response, and asynchronous reset.
module tb_if_fetch_unit;
  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_PC, i_PC_4, i_imem_rdata;
  logic        i_imem_gnt, i_imem_rvalid, i_ready, i_flush;
  logic        o_pc_stall, o_imem_req, o_valid, o_dbg_state;
  logic [31:0] o_imem_addr, o_instr, o_instr_pc_4;
  logic [2:0]  o_dbg_alloc_cnt, o_dbg_drop_cnt;

  int checks = 0;
  int errors = 0;
  int pend   = 0;

  if_fetch_unit #(.NBITS(32), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_PC(i_PC), .i_PC_4(i_PC_4),
    .o_pc_stall(o_pc_stall), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_instr_pc_4(o_instr_pc_4),
    .i_flush(i_flush), .o_dbg_state(o_dbg_state),
    .o_dbg_alloc_cnt(o_dbg_alloc_cnt), .o_dbg_drop_cnt(o_dbg_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Memory-side count of granted but unanswered requests; memory shares the reset.
  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) pend <= 0;
    else pend <= pend + int'(o_imem_req & i_imem_gnt) - int'(i_imem_rvalid);
  end

  always @(negedge i_clk) begin
    if (i_reset && i_imem_rvalid) begin
      checks++;
      assert (pend > 0)
      else begin
        errors++;
        $error("FAIL rvalid_protocol: pending=%0d required>0", pend);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_imem_gnt = 0; i_imem_rvalid = 0; i_imem_rdata = '0;
    i_ready = 0; i_flush = 0;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    i_PC = pc; i_PC_4 = pc + 32'd4;
  endtask

  task automatic single_fetch(input string tag, input logic [31:0] data);
    idle(); set_pc(32'h0); i_imem_gnt = 1; i_ready = 1;
    #1;
    chk({tag, "_req"}, o_imem_req, 1);
    chk({tag, "_stall"}, o_pc_stall, 0);
    chk({tag, "_addr"}, o_imem_addr, 32'h0);
    cyc();
    i_imem_gnt = 0; i_imem_rvalid = 1; i_imem_rdata = data;
    #1;
    chk({tag, "_nobypass"}, o_valid, 0);
    chk({tag, "_alloc1"}, o_dbg_alloc_cnt, 1);
    cyc();
    i_imem_rvalid = 0;
    #1;
    chk({tag, "_valid"}, o_valid, 1);
    chk({tag, "_instr"}, o_instr, data);
    chk({tag, "_pc4"}, o_instr_pc_4, 32'h4);
    cyc();
    chk({tag, "_alloc0"}, o_dbg_alloc_cnt, 0);
    chk({tag, "_empty"}, o_valid, 0);
  endtask

  initial begin
    logic [31:0] bp_data [4];
    bp_data[0] = 32'h1111_0001; bp_data[1] = 32'h2222_0002;
    bp_data[2] = 32'h3333_0003; bp_data[3] = 32'h4444_0004;
    idle(); set_pc(32'h0);
    i_reset = 1;
    #1 i_reset = 0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_req", o_imem_req, 0);
    chk("rst_stall", o_pc_stall, 1);
    chk("rst_instr", o_instr, 0);
    chk("rst_pc4", o_instr_pc_4, 0);
    chk("rst_state", o_dbg_state, 0);
    i_reset = 1;
    cyc();

    single_fetch("sf", 32'h2008_0005);

    // Backpressure: four accepts with 1-cycle latency, decode not ready.
    idle(); i_imem_gnt = 1;
    for (int i = 0; i < 5; i++) begin
      set_pc(32'(i * 4));
      i_imem_rvalid = (i > 0);
      i_imem_rdata  = (i > 0) ? bp_data[i-1] : 32'h0;
      #1;
      if (i == 4) begin
        chk("bp_full_req", o_imem_req, 0);
        chk("bp_full_stall", o_pc_stall, 1);
        chk("bp_full_alloc", o_dbg_alloc_cnt, 4);
      end else begin
        chk("bp_accept", o_pc_stall, 0);
      end
      cyc();
    end
    idle();
    #1;
    chk("bp_held_valid", o_valid, 1);
    chk("bp_held_req", o_imem_req, 0);
    cyc();
    i_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_pop_valid", o_valid, 1);
      chk("bp_pop_instr", o_instr, bp_data[i]);
      chk("bp_pop_pc4", o_instr_pc_4, 32'((i + 1) * 4));
      chk("bp_req", o_imem_req, (i == 0) ? 0 : 1);
      cyc();
    end
    chk("bp_drained", o_dbg_alloc_cnt, 0);

    // Grant stall: PC must hold while memory withholds gnt.
    idle(); set_pc(32'h20);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("gs_stall", o_pc_stall, 1);
      chk("gs_alloc", o_dbg_alloc_cnt, 0);
      cyc();
    end
    i_imem_gnt = 1;
    #1;
    chk("gs_accept", o_pc_stall, 0);
    cyc();
    chk("gs_alloc1", o_dbg_alloc_cnt, 1);
    i_imem_gnt = 0; i_imem_rvalid = 1; i_imem_rdata = 32'hCAFE_0020;
    cyc();
    i_imem_rvalid = 0; i_ready = 1;
    #1;
    chk("gs_instr", o_instr, 32'hCAFE_0020);
    chk("gs_pc4", o_instr_pc_4, 32'h24);
    cyc();

    // Flush before any response: two responses must be discarded.
    idle(); i_imem_gnt = 1; set_pc(32'h10);
    cyc();
    set_pc(32'h14);
    cyc();
    i_flush = 1;
    #1;
    chk("fl_req", o_imem_req, 0);
    chk("fl_stall", o_pc_stall, 1);
    cyc();
    i_flush = 0; set_pc(32'h40); i_ready = 1;
    i_imem_rvalid = 1; i_imem_rdata = 32'hBAD0_0010;
    #1;
    chk("fl_state", o_dbg_state, 1);
    chk("fl_drop2", o_dbg_drop_cnt, 2);
    chk("fl_valid", o_valid, 0);
    chk("fl_req_drain", o_imem_req, 0);
    cyc();
    i_imem_rdata = 32'hBAD0_0014;
    #1;
    chk("fl_drop1", o_dbg_drop_cnt, 1);
    chk("fl_req_drain1", o_imem_req, 0);
    cyc();
    i_imem_rvalid = 0;
    #1;
    chk("fl_run", o_dbg_state, 0);
    chk("fl_alloc0", o_dbg_alloc_cnt, 0);
    chk("fl_no_stale", o_valid, 0);
    chk("fl_req_run", o_imem_req, 1);
    cyc();
    i_imem_gnt = 0; i_imem_rvalid = 1; i_imem_rdata = 32'h4040_4040;
    #1;
    chk("fl_no_stale2", o_valid, 0);
    cyc();
    i_imem_rvalid = 0;
    #1;
    chk("fl_instr", o_instr, 32'h4040_4040);
    chk("fl_pc4", o_instr_pc_4, 32'h44);
    cyc();

    // Flush coincident with a response: only one more response to drop.
    idle(); i_imem_gnt = 1; set_pc(32'h50);
    cyc();
    set_pc(32'h54);
    cyc();
    i_imem_gnt = 0; i_flush = 1; i_imem_rvalid = 1; i_imem_rdata = 32'hDEAD_0050;
    cyc();
    i_flush = 0; i_imem_rdata = 32'hDEAD_0054;
    #1;
    chk("fc_state", o_dbg_state, 1);
    chk("fc_drop1", o_dbg_drop_cnt, 1);
    cyc();
    i_imem_rvalid = 0;
    #1;
    chk("fc_run", o_dbg_state, 0);
    chk("fc_drop0", o_dbg_drop_cnt, 0);
    chk("fc_req", o_imem_req, 1);
    chk("fc_valid", o_valid, 0);

    // Asynchronous reset with three queued instructions.
    idle(); i_imem_gnt = 1; set_pc(32'h60);
    cyc();
    set_pc(32'h64); i_imem_rvalid = 1; i_imem_rdata = 32'hE000_0060;
    cyc();
    set_pc(32'h68); i_imem_rdata = 32'hE000_0064;
    cyc();
    i_imem_gnt = 0; i_imem_rdata = 32'hE000_0068;
    cyc();
    idle();
    #1;
    chk("ar_valid_pre", o_valid, 1);
    chk("ar_alloc3", o_dbg_alloc_cnt, 3);
    #2 i_reset = 0;
    #1;
    chk("ar_valid", o_valid, 0);
    chk("ar_req", o_imem_req, 0);
    chk("ar_stall", o_pc_stall, 1);
    chk("ar_alloc0", o_dbg_alloc_cnt, 0);
    chk("ar_instr", o_instr, 0);
    cyc();
    i_reset = 1;
    cyc();
    single_fetch("ar_sf", 32'h2008_0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
